// File: rtl/sweep_job_scheduler.sv
// Round-robin scheduler sharing one frequency_sweeper between NUM_REQ requesters.
// Optional abort input enabled by defining SWEEP_SCHED_ABORT_EN.
module sweep_job_scheduler #(
    parameter  int NUM_REQ         = 4,
    parameter  int START_TIMEOUT   = 256,
    parameter  int PLL_HOLD_CYCLES = 65536,
    localparam int IW              = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
`ifdef SWEEP_SCHED_ABORT_EN
    input  logic                    abort,
`endif
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ-1:0]      req_mode,
    input  logic [32*NUM_REQ-1:0]   req_init_freq,
    input  logic [16*NUM_REQ-1:0]   req_cycles,
    input  logic [32*NUM_REQ-1:0]   req_step,
    input  logic                    fifo_full,
    output logic                    fifo_wr_en,
    output logic [87:0]             fifo_wdata,
    input  logic                    sweep_start,
    input  logic                    sweep_done,
    input  logic                    pll_enable,
    output logic                    sweeper_rst,
    output logic                    busy,
    output logic [IW-1:0]           grant_id,
    output logic                    job_done,
    output logic                    job_err
);

    typedef enum logic [2:0] {
        IDLE, WRITE, WAIT_START, WAIT_DONE, PLL_HOLD, RECOVER, RELEASE
    } state_t;

    state_t          r_state, w_next;
    logic [31:0]     r_cnt;
    logic [IW-1:0]   r_last;
    logic [IW-1:0]   w_winner;
    logic [IW:0]     w_sum;
    logic            w_found;
    logic            w_grant;
    logic            w_abort;
    logic            w_done_nxt;
    logic            w_err_nxt;

`ifdef SWEEP_SCHED_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Round-robin search beginning one past the previous owner.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_sum    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_sum = {1'b0, r_last} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(NUM_REQ))
                w_sum = w_sum - (IW+1)'(NUM_REQ);
            if (!w_found && req_valid[w_sum[IW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[IW-1:0];
            end
        end
    end

    assign w_grant = (r_state == IDLE) && (w_next == WRITE);

    always_comb begin
        w_next     = r_state;
        w_done_nxt = 1'b0;
        w_err_nxt  = 1'b0;
        case (r_state)
            IDLE:       if (w_found && !fifo_full) w_next = WRITE;
            WRITE: begin
                w_next = WAIT_START;
                if (w_abort) begin
                    w_next    = RECOVER;
                    w_err_nxt = 1'b1;
                end
            end
            WAIT_START: begin
                if (w_abort) begin
                    w_next    = RECOVER;
                    w_err_nxt = 1'b1;
                end else if (fifo_wdata[87] ? pll_enable : sweep_start) begin
                    w_next = fifo_wdata[87] ? PLL_HOLD : WAIT_DONE;
                end else if (r_cnt == 32'(START_TIMEOUT - 1)) begin
                    w_next    = RECOVER;
                    w_err_nxt = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (w_abort) begin
                    w_next    = RECOVER;
                    w_err_nxt = 1'b1;
                end else if (sweep_done) begin
                    w_next     = RELEASE;
                    w_done_nxt = 1'b1;
                end
            end
            PLL_HOLD: begin
                if (w_abort) begin
                    w_next    = RECOVER;
                    w_err_nxt = 1'b1;
                end else if (r_cnt == 32'(PLL_HOLD_CYCLES - 1)) begin
                    w_next     = RECOVER;
                    w_done_nxt = 1'b1;
                end
            end
            RECOVER:    if (r_cnt == 32'd1) w_next = RELEASE;
            RELEASE:    w_next = IDLE;
            default:    w_next = IDLE;
        endcase
    end

    // All outputs are registered from the next-state decision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_last      <= IW'(NUM_REQ - 1);
            req_ready   <= '0;
            fifo_wr_en  <= 1'b0;
            fifo_wdata  <= '0;
            sweeper_rst <= 1'b0;
            busy        <= 1'b0;
            grant_id    <= '0;
            job_done    <= 1'b0;
            job_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            // One counter serves start timeout, PLL hold and recover length.
            if (w_next != r_state)
                r_cnt <= '0;
            else if (r_cnt != '1)
                r_cnt <= r_cnt + 32'd1;
            req_ready   <= w_grant ? (NUM_REQ'(1) << w_winner) : '0;
            fifo_wr_en  <= (r_state == WRITE);
            sweeper_rst <= (w_next == RECOVER);
            busy        <= (w_next != IDLE);
            job_done    <= w_done_nxt;
            job_err     <= w_err_nxt;
            if (w_grant) begin
                grant_id   <= w_winner;
                fifo_wdata <= {req_mode[w_winner], 7'(w_winner),
                               req_init_freq[{w_winner, 5'b0} +: 32],
                               req_cycles[{w_winner, 4'b0} +: 16],
                               req_step[{w_winner, 5'b0} +: 32]};
            end
            if (r_state == RELEASE)
                r_last <= grant_id;
        end
    end

endmodule

// File: tb/tb_sweep_job_scheduler.sv
// Directed bench for sweep_job_scheduler: sweep, round-robin, PLL hold, timeout, backpressure, reset.
module tb_sweep_job_scheduler;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_ready, req_mode;
    logic [32*N-1:0] req_init_freq, req_step;
    logic [16*N-1:0] req_cycles;
    logic            fifo_full, fifo_wr_en;
    logic [87:0]     fifo_wdata;
    logic            sweep_start, sweep_done, pll_enable;
    logic            sweeper_rst, busy, job_done, job_err;
    logic [1:0]      grant_id;

    int n_asserts = 0;
    int n_fail    = 0;

    sweep_job_scheduler #(.NUM_REQ(N), .START_TIMEOUT(256), .PLL_HOLD_CYCLES(65536)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_init_freq(req_init_freq), .req_cycles(req_cycles), .req_step(req_step),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata),
        .sweep_start(sweep_start), .sweep_done(sweep_done), .pll_enable(pll_enable),
        .sweeper_rst(sweeper_rst), .busy(busy), .grant_id(grant_id),
        .job_done(job_done), .job_err(job_err)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [87:0] obs, input logic [87:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_req(input int i, input logic m, input logic [31:0] f,
                           input logic [15:0] c, input logic [31:0] s);
        req_mode[i]              = m;
        req_init_freq[32*i +: 32] = f;
        req_cycles[16*i +: 16]    = c;
        req_step[32*i +: 32]      = s;
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (req_ready == '0 && k < 20) begin
            tick();
            k++;
        end
        check({tag, "_ready_seen"}, 88'(req_ready != '0), 88'd1);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0; req_mode = '0; req_init_freq = '0; req_cycles = '0; req_step = '0;
        fifo_full = 1'b0; sweep_start = 1'b0; sweep_done = 1'b0; pll_enable = 1'b0;
        tick(2);
        check("rst_outs", {req_ready, fifo_wr_en, sweeper_rst, busy, grant_id, job_done, job_err}, '0);
        check("rst_wdata", fifo_wdata, '0);
        reset = 1'b0;
        tick();

        // Single sweep job on requester 0
        set_req(0, 1'b0, 32'h1000_0000, 16'd3, 32'h10);
        req_valid = 4'b0001;
        tick();
        check("s_ready", 88'(req_ready), 88'h1);
        check("s_wdata", fifo_wdata, 88'h00_1000_0000_0003_0000_0010);
        check("s_busy", 88'(busy), 88'd1);
        check("s_wr_early", 88'(fifo_wr_en), 88'd0);
        req_valid = '0;
        tick();
        check("s_wr", 88'(fifo_wr_en), 88'd1);
        check("s_ready_clr", 88'(req_ready), 88'h0);
        tick();
        check("s_wr_once", 88'(fifo_wr_en), 88'd0);
        tick(2);
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        tick();
        sweep_done = 1'b1;
        tick();
        sweep_done = 1'b0;
        check("s_done", 88'({job_done, job_err, sweeper_rst, busy}), 88'b1001);
        tick();
        check("s_idle", 88'({job_done, busy}), 88'b00);
        sweep_done = 1'b1;
        tick();
        sweep_done = 1'b0;
        check("s_done_ignored", 88'(job_done), 88'd0);

        // Round-robin after reset: grants 0,1,2,3,0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++)
            set_req(i, 1'b0, 32'hA000_0000 + 32'(i), 16'(i + 1), 32'h100 * 32'(i));
        req_valid = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_ready("rr");
            check("rr_ready", 88'(req_ready), 88'(4'b0001 << (j % 4)));
            check("rr_grant", 88'(grant_id), 88'(j % 4));
            if (j == 1)
                check("rr_wdata", fifo_wdata, {1'b0, 7'd1, 32'hA000_0001, 16'h0002, 32'h0000_0100});
            tick();
            check("rr_ready_pulse", 88'(req_ready), 88'h0);
            sweep_start = 1'b1;
            tick();
            sweep_start = 1'b0;
            sweep_done = 1'b1;
            tick();
            sweep_done = 1'b0;
            check("rr_done", 88'(job_done), 88'd1);
            tick();
        end
        req_valid = '0;
        tick();

        // PLL job on requester 2
        set_req(2, 1'b1, 32'h2222_0000, 16'd7, 32'h5);
        req_valid = 4'b0100;
        tick();
        check("p_ready", 88'(req_ready), 88'h4);
        check("p_idx", 88'(fifo_wdata[87:80]), 88'h82);
        req_valid = '0;
        tick();
        check("p_wr", 88'(fifo_wr_en), 88'd1);
        sweep_start = 1'b1;
        tick(4);
        sweep_start = 1'b0;
        check("p_sweep_start_ignored", 88'({busy, job_done, job_err}), 88'b100);
        pll_enable = 1'b1;
        tick();
        tick(65535);
        check("p_hold_early", 88'({job_done, sweeper_rst}), 88'b00);
        tick();
        check("p_done", 88'({job_done, job_err, sweeper_rst}), 88'b101);
        pll_enable = 1'b0;
        tick();
        check("p_rst2", 88'({job_done, sweeper_rst}), 88'b01);
        tick();
        check("p_rst_end", 88'({sweeper_rst, busy}), 88'b01);
        tick();
        check("p_idle", 88'(busy), 88'd0);

        // Start timeout on requester 3
        req_valid = 4'b1000;
        tick();
        check("t_ready", 88'(req_ready), 88'h8);
        req_valid = '0;
        tick();
        tick(255);
        check("t_err_early", 88'({job_err, sweeper_rst}), 88'b00);
        tick();
        check("t_err", 88'({job_err, job_done, sweeper_rst}), 88'b101);
        tick();
        check("t_rst2", 88'({job_err, sweeper_rst}), 88'b01);
        tick();
        check("t_rst_end", 88'(sweeper_rst), 88'd0);
        tick();
        check("t_idle", 88'(busy), 88'd0);

        // Backpressure on requester 1
        fifo_full = 1'b1;
        req_valid = 4'b0010;
        tick(3);
        check("b_blocked", 88'({req_ready, fifo_wr_en, busy}), 88'h0);
        fifo_full = 1'b0;
        tick();
        check("b_ready", 88'(req_ready), 88'h2);
        req_valid = '0;
        tick();
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        tick(2);
        check("r_pre_busy", 88'(busy), 88'd1);

        // Reset during WAIT_DONE
        reset = 1'b1;
        #1;
        check("r_outs", {req_ready, fifo_wr_en, sweeper_rst, busy, grant_id, job_done, job_err}, '0);
        check("r_wdata", fifo_wdata, '0);
        tick();
        reset = 1'b0;
        tick();
        check("r_quiet", 88'({job_done, job_err, sweeper_rst}), 88'b000);
        req_valid = 4'b0101;
        wait_ready("r");
        check("r_first_grant", 88'(req_ready), 88'h1);

        // Start evidence on the timeout cycle wins
        req_valid = '0;
        tick();
        tick(255);
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        check("e_start_wins", 88'({job_err, sweeper_rst, busy}), 88'b001);
        sweep_done = 1'b1;
        tick();
        sweep_done = 1'b0;
        check("e_done", 88'(job_done), 88'd1);
        tick();
        check("e_idle", 88'(busy), 88'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
